// File: rtl/shift_req_sequencer.sv
// shift_req_sequencer: initiator-side controller for the registered shift unit.
// Buffers shift requests in a FIFO and issues each one as a single-cycle enable
// pulse. It captures the result one cycle after issue and returns it on a
// valid/ready response port.
// Optional feature macro: SHSEQ_SRA_FIX_EN sign-fills SRA results when the
// issued operand is negative.
module shift_req_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SH_W   = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [SH_W-1:0]   req_shamt,
    input  logic [2:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_op,
    output logic              rsp_err,
    output logic              alu_enable,
    output logic [DATA_W-1:0] alu_in,
    output logic [SH_W-1:0]   alu_shift,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + SH_W + 3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ENT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic [DATA_W-1:0]   r_alu_in;
    logic [SH_W-1:0]     r_alu_shift;
    logic [2:0]          r_alu_op;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [2:0]          r_rsp_op;
    logic                r_rsp_err;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENT_W-1:0]    w_head;
    logic [DATA_W-1:0]   w_head_data;
    logic [SH_W-1:0]     w_head_shamt;
    logic [2:0]          w_head_op;
    logic                w_head_illegal;
    logic [DATA_W-1:0]   w_capture;

`ifdef SHSEQ_SRA_FIX_EN
    logic [DATA_W-1:0]   r_sra_opnd;
    logic [SH_W-1:0]     r_sra_shamt;
`endif

    assign w_full         = (r_count == CNT_W'(DEPTH));
    assign w_empty        = (r_count == '0);
    // Ready is suppressed while reset is held so nothing is accepted then.
    assign req_ready      = RESET && !w_full;
    assign w_push         = req_valid && req_ready;
    assign w_pop          = (r_state == StIdle) && !w_empty;

    assign w_head         = r_mem[r_rptr];
    assign w_head_data    = w_head[DATA_W-1:0];
    assign w_head_shamt   = w_head[DATA_W+SH_W-1:DATA_W];
    assign w_head_op      = w_head[ENT_W-1:DATA_W+SH_W];
    assign w_head_illegal = w_head_op[2];

    // FIFO storage; entries need no reset because the count gates every read.
    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_mem[r_wptr] <= {req_op, req_shamt, req_data};
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; illegal ops skip the shift unit entirely.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_next = w_head_illegal ? StHold : StIssue;
                end
            end
            StIssue: w_state_next = StWait;
            StWait:  w_state_next = StHold;
            StHold: begin
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        alu_enable = (r_state == StIssue);
        rsp_valid  = (r_state == StHold);
        busy       = (r_state != StIdle) || !w_empty;
    end

    // Result as stored at WAIT; optionally repairs a zero-filled SRA.
    always_comb begin
        w_capture = alu_result;
`ifdef SHSEQ_SRA_FIX_EN
        if ((r_alu_op == 3'b011) && r_sra_opnd[DATA_W-1]) begin
            w_capture = alu_result | ~({DATA_W{1'b1}} >> r_sra_shamt);
        end
`endif
    end

    // Operand and response registers; both hold until explicitly reloaded.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_alu_in    <= '0;
            r_alu_shift <= '0;
            r_alu_op    <= '0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
            r_rsp_err   <= 1'b0;
`ifdef SHSEQ_SRA_FIX_EN
            r_sra_opnd  <= '0;
            r_sra_shamt <= '0;
`endif
        end else begin
            if (w_pop) begin
                if (w_head_illegal) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                    r_rsp_op   <= w_head_op;
                end else begin
                    r_alu_in    <= w_head_data;
                    r_alu_shift <= w_head_shamt;
                    r_alu_op    <= w_head_op;
`ifdef SHSEQ_SRA_FIX_EN
                    r_sra_opnd  <= w_head_data;
                    r_sra_shamt <= w_head_shamt;
`endif
                end
            end
            if (r_state == StWait) begin
                r_rsp_data <= w_capture;
                r_rsp_err  <= 1'b0;
                r_rsp_op   <= r_alu_op;
            end
        end
    end

    assign alu_in    = r_alu_in;
    assign alu_shift = r_alu_shift;
    assign alu_op    = r_alu_op;
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_rsp_op;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_shift_req_sequencer.sv
// Directed testbench for shift_req_sequencer with a behavioural shift unit.
// The shift unit model treats SRA as a logical right shift, so the sequencer's
// optional SHSEQ_SRA_FIX_EN repair is visible in the SRA result.
module tb_shift_req_sequencer;

    localparam int DEPTH = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = '0;
    logic [4:0]  req_shamt = '0;
    logic [2:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        alu_enable;
    logic [31:0] alu_in;
    logic [4:0]  alu_shift;
    logic [2:0]  alu_op;
    logic [31:0] alu_result = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_high = 0;
    int n_rise = 0;
    logic en_prev = 1'b0;

    shift_req_sequencer #(
        .DEPTH (DEPTH),
        .DATA_W(32),
        .SH_W  (5)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err),
        .alu_enable(alu_enable),
        .alu_in    (alu_in),
        .alu_shift (alu_shift),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .busy      (busy)
    );

    always #5 CLOCK = ~CLOCK;

    // Registered shift unit; SRA deliberately zero-fills.
    always @(posedge CLOCK) begin
        if (alu_enable) begin
            case (alu_op)
                3'b000, 3'b001: alu_result <= alu_in << alu_shift;
                default:        alu_result <= alu_in >> alu_shift;
            endcase
        end
    end

    // Enable pulse statistics: high cycles and rising edges.
    always @(posedge CLOCK) begin
        if (alu_enable) n_high <= n_high + 1;
        if (alu_enable && !en_prev) n_rise <= n_rise + 1;
        en_prev <= alu_enable;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push one request (entered at a negedge), wait for its response, and
    // let it handshake. Returns at a negedge with the FSM back in IDLE.
    task automatic run_req(input logic [2:0] op, input logic [31:0] data, input logic [4:0] sh,
                           output logic [31:0] d, output logic err, output logic [2:0] o,
                           output logic ok);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_shamt = sh;
        @(posedge CLOCK);
        @(negedge CLOCK);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLOCK);
        ok  = rsp_valid;
        d   = rsp_data;
        err = rsp_err;
        o   = rsp_op;
        @(negedge CLOCK);
    endtask

    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    logic        ok;
    logic        w;
    logic        saw;
    int          base_h;
    int          base_r;
    int          n_acc;

    initial begin
        // Reset held for two edges.
        RESET = 1'b0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_req_ready_held", 32'(req_ready), 32'd0);
        RESET = 1'b1;
        #1;
        chk("rst_req_ready_released", 32'(req_ready), 32'd1);

        // SLL latency walk: accept at edge 0, enable after edge 1, rsp after edge 3.
        rsp_ready = 1'b1;
        base_h    = n_high;
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_data  = 32'h0000_0001;
        req_shamt = 5'd4;
        @(posedge CLOCK);
        @(negedge CLOCK);
        req_valid = 1'b0;
        chk("sll_e0_enable", 32'(alu_enable), 32'd0);
        chk("sll_e0_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge CLOCK);
        chk("sll_e1_enable", 32'(alu_enable), 32'd1);
        chk("sll_e1_alu_in", alu_in, 32'h0000_0001);
        chk("sll_e1_alu_shift", 32'(alu_shift), 32'd4);
        chk("sll_e1_alu_op", 32'(alu_op), 32'd0);
        @(negedge CLOCK);
        chk("sll_e2_enable", 32'(alu_enable), 32'd0);
        chk("sll_e2_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("sll_e2_alu_in_hold", alu_in, 32'h0000_0001);
        @(negedge CLOCK);
        chk("sll_e3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sll_e3_rsp_data", rsp_data, 32'h0000_0010);
        chk("sll_e3_rsp_err", 32'(rsp_err), 32'd0);
        chk("sll_e3_rsp_op", 32'(rsp_op), 32'd0);
        @(negedge CLOCK);
        chk("sll_e4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("sll_pulses", 32'(n_high - base_h), 32'd1);

        // SRA on a negative operand.
        run_req(3'b011, 32'h8000_0000, 5'd4, d, e, o, ok);
        chk("sra_timeout", 32'(ok), 32'd1);
`ifdef SHSEQ_SRA_FIX_EN
        chk("sra_data", d, 32'hF800_0000);
`else
        chk("sra_data", d, 32'h0800_0000);
`endif
        chk("sra_op", 32'(o), 32'd3);

        // Shift amount zero returns the operand.
        run_req(3'b010, 32'h1234_5678, 5'd0, d, e, o, ok);
        chk("sh0_timeout", 32'(ok), 32'd1);
        chk("sh0_data", d, 32'h1234_5678);

        // SLA behaves as a left shift.
        run_req(3'b001, 32'h0000_0003, 5'd2, d, e, o, ok);
        chk("sla_timeout", 32'(ok), 32'd1);
        chk("sla_data", d, 32'h0000_000C);
        chk("sla_op", 32'(o), 32'd1);

        // Illegal op: response after edge 1, no enable, held while not ready.
        rsp_ready = 1'b0;
        base_h    = n_high;
        req_valid = 1'b1;
        req_op    = 3'b101;
        req_data  = 32'hDEAD_BEEF;
        req_shamt = 5'd0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        req_valid = 1'b0;
        chk("ill_e0_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge CLOCK);
        chk("ill_e1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ill_e1_rsp_err", 32'(rsp_err), 32'd1);
        chk("ill_e1_rsp_data", rsp_data, 32'd0);
        chk("ill_e1_rsp_op", 32'(rsp_op), 32'd5);
        chk("ill_e1_enable", 32'(alu_enable), 32'd0);
        @(negedge CLOCK);
        chk("ill_hold_valid", 32'(rsp_valid), 32'd1);
        chk("ill_hold_err", 32'(rsp_err), 32'd1);
        rsp_ready = 1'b1;
        @(negedge CLOCK);
        chk("ill_done_valid", 32'(rsp_valid), 32'd0);
        chk("ill_pulses", 32'(n_high - base_h), 32'd0);

        // Back-pressure: fill FIFO plus the HOLD slot.
        rsp_ready = 1'b0;
        base_h    = n_high;
        base_r    = n_rise;
        n_acc     = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = 1'b1;
            req_op    = 3'b010;
            req_data  = 32'h0000_0100 << n_acc;
            req_shamt = 5'd8;
            #1;
            w = req_ready;
            @(posedge CLOCK);
            if (w) n_acc++;
            @(negedge CLOCK);
        end
        req_valid = 1'b0;
        chk("fill_accepted", 32'(n_acc), 32'(DEPTH + 1));
        chk("fill_req_ready", 32'(req_ready), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);

        // Drain in order.
        rsp_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLOCK);
            chk($sformatf("drain%0d_timeout", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("drain%0d_data", k), rsp_data, 32'd1 << k);
            @(negedge CLOCK);
        end
        chk("drain_high_cycles", 32'(n_high - base_h), 32'(DEPTH + 1));
        chk("drain_rises", 32'(n_rise - base_r), 32'(DEPTH + 1));
        chk("drain_busy", 32'(busy), 32'd0);

        // Reset while in WAIT discards the request.
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_data  = 32'h0000_0003;
        req_shamt = 5'd1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        req_valid = 1'b0;
        @(negedge CLOCK);
        chk("rw_issue_enable", 32'(alu_enable), 32'd1);
        @(negedge CLOCK);
        chk("rw_wait_enable", 32'(alu_enable), 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("rw_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_rst_busy", 32'(busy), 32'd0);
        chk("rw_rst_rsp_data", rsp_data, 32'd0);
        RESET = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK);
            if (rsp_valid) saw = 1'b1;
        end
        chk("rw_no_rsp", 32'(saw), 32'd0);
        chk("rw_busy_after", 32'(busy), 32'd0);
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        run_req(3'b000, 32'h0000_0003, 5'd1, d, e, o, ok);
        chk("rw_next_timeout", 32'(ok), 32'd1);
        chk("rw_next_data", d, 32'h0000_0006);
        chk("rw_next_err", 32'(e), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
